// File: rtl/mem_bridge.sv
// mem_bridge
// ----------
// Bridge between the multicycle datapath/controller and a variable-latency
// unified instruction/data memory. A read or write strobe from the controller
// is turned into a req/ack transaction on the memory side. Read data is
// captured into ReadData, and a one-cycle MemReady pulse marks completion,
// whether the access succeeded or failed. Misaligned addresses are rejected
// without touching memory. A request left unacknowledged for TIMEOUT cycles
// is aborted with MemErr set.
//
// Handshake: m_req is held high with m_addr/m_we/m_wdata stable until the
// first cycle in which m_ack is sampled high. That cycle completes the
// transfer, and m_rdata is taken in that same cycle on reads. An m_ack seen
// while no request is outstanding is ignored.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-low reset
//   Adr        byte address from the datapath
//   WriteData  store data from the datapath
//   MemRead    read strobe (level) from the controller
//   MemWrite   write strobe (level) from the controller
//   ReadData   last captured read word
//   MemReady   one-cycle completion pulse (success or error)
//   MemErr     error flag of the most recent access
//   m_req      memory request
//   m_we       memory write enable, valid with m_req
//   m_addr     word-aligned memory address
//   m_wdata    memory write data
//   m_ack      memory acknowledge
//   m_rdata    memory read data, valid with m_ack on reads
module mem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // The counter value in the last cycle m_req may be high. Reaching it
    // without an ack aborts, so m_req stays high for exactly TIMEOUT cycles.
    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] count;
    logic        strobe;

    assign strobe = MemRead | MemWrite;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            ReadData <= '0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        if (Adr[1:0] == 2'b00) begin
                            // Write wins when both strobes are high.
                            m_addr  <= {Adr[31:2], 2'b00};
                            m_wdata <= WriteData;
                            m_we    <= MemWrite;
                            count   <= '0;
                            m_req   <= 1'b1;
                            MemErr  <= 1'b0;
                            state   <= REQ;
                        end else begin
                            // Rejected without issuing a memory request.
                            // The error flag goes up together with MemReady.
                            MemReady <= 1'b1;
                            MemErr   <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                REQ: begin
                    if (m_ack) begin
                        if (!m_we) begin
                            ReadData <= m_rdata;
                        end
                        m_req    <= 1'b0;
                        MemReady <= 1'b1;
                        state    <= DONE;
                    end else if (count == COUNT_LAST) begin
                        m_req    <= 1'b0;
                        MemReady <= 1'b1;
                        MemErr   <= 1'b1;
                        state    <= ERR;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                DONE, ERR: begin
                    // Completion cycle. The strobes are ignored here, so a
                    // new access can start in the following IDLE cycle.
                    MemReady <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
// -------------
// Directed bench for mem_bridge with TIMEOUT=4. Inputs are driven 1 time unit
// after each rising edge, and outputs are sampled at that same point. Cycle
// numbers in the comments count from the cycle in which the strobe is first
// driven (cycle 0).
module tb_mem_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int checks;
    int failures;

    mem_bridge #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Adr       (Adr),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .MemReady  (MemReady),
        .MemErr    (MemErr),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Adr = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
        m_ack = 1'b0; m_rdata = '0;
        step(); step();
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rst_m_req: got %b exp 0", m_req); end
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL rst_m_we: got %b exp 0", m_we); end
        checks++; if (m_addr !== 32'h0) begin failures++; $display("FAIL rst_m_addr: got %h exp 0", m_addr); end
        checks++; if (m_wdata !== 32'h0) begin failures++; $display("FAIL rst_m_wdata: got %h exp 0", m_wdata); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h exp 0", ReadData); end
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b exp 0", MemReady); end
        checks++; if (MemErr !== 1'b0) begin failures++; $display("FAIL rst_err: got %b exp 0", MemErr); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_zero_wait_read();
        // cycle 0
        Adr = 32'h100; MemRead = 1'b1;
        step();
        // cycle 1
        checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL zw_m_req: got %b exp 1", m_req); end
        checks++; if (m_addr !== 32'h100) begin failures++; $display("FAIL zw_m_addr: got %h exp 00000100", m_addr); end
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL zw_m_we: got %b exp 0", m_we); end
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL zw_ready_c1: got %b exp 0", MemReady); end
        MemRead = 1'b0; m_ack = 1'b1; m_rdata = 32'hE3A01005;
        step();
        // cycle 2
        m_ack = 1'b0;
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL zw_ready: got %b exp 1", MemReady); end
        checks++; if (ReadData !== 32'hE3A01005) begin failures++; $display("FAIL zw_rdata: got %h exp e3a01005", ReadData); end
        checks++; if (MemErr !== 1'b0) begin failures++; $display("FAIL zw_err: got %b exp 0", MemErr); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL zw_req_drop: got %b exp 0", m_req); end
        step();
        // cycle 3
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL zw_ready_pulse: got %b exp 0", MemReady); end
    endtask

    task automatic test_write_wait();
        // cycle 0
        Adr = 32'h200; WriteData = 32'hCAFEF00D; MemWrite = 1'b1;
        step();
        MemWrite = 1'b0;
        WriteData = 32'h0BAD0BAD;    // must not leak into the held m_wdata
        for (int c = 1; c <= 4; c++) begin
            checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL wr_m_req c%0d: got %b exp 1", c, m_req); end
            checks++; if (m_we !== 1'b1) begin failures++; $display("FAIL wr_m_we c%0d: got %b exp 1", c, m_we); end
            checks++; if (m_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_m_wdata c%0d: got %h exp cafef00d", c, m_wdata); end
            checks++; if (m_addr !== 32'h200) begin failures++; $display("FAIL wr_m_addr c%0d: got %h exp 00000200", c, m_addr); end
            checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL wr_ready_early c%0d: got %b exp 0", c, MemReady); end
            if (c == 4) begin
                m_ack = 1'b1; m_rdata = 32'h99999999;
            end
            step();
        end
        // cycle 5
        m_ack = 1'b0;
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b exp 1", MemReady); end
        checks++; if (ReadData !== 32'hE3A01005) begin failures++; $display("FAIL wr_rdata_kept: got %h exp e3a01005", ReadData); end
        checks++; if (MemErr !== 1'b0) begin failures++; $display("FAIL wr_err: got %b exp 0", MemErr); end
        step();
    endtask

    task automatic test_misaligned();
        // cycle 0
        Adr = 32'h102; MemRead = 1'b1;
        step();
        // cycle 1
        MemRead = 1'b0;
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL mis_m_req: got %b exp 0", m_req); end
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL mis_ready: got %b exp 1", MemReady); end
        checks++; if (MemErr !== 1'b1) begin failures++; $display("FAIL mis_err: got %b exp 1", MemErr); end
        step();
        // cycle 2: back in IDLE, flag held
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL mis_ready_pulse: got %b exp 0", MemReady); end
        checks++; if (MemErr !== 1'b1) begin failures++; $display("FAIL mis_err_hold: got %b exp 1", MemErr); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL mis_m_req_c2: got %b exp 0", m_req); end
        Adr = 32'h104; MemRead = 1'b1;
        step();
        // cycle 3: aligned read accepted, error cleared
        checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL mis2_m_req: got %b exp 1", m_req); end
        checks++; if (MemErr !== 1'b0) begin failures++; $display("FAIL mis2_err_clr: got %b exp 0", MemErr); end
        MemRead = 1'b0; m_ack = 1'b1; m_rdata = 32'h11223344;
        step();
        m_ack = 1'b0;
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL mis2_ready: got %b exp 1", MemReady); end
        checks++; if (ReadData !== 32'h11223344) begin failures++; $display("FAIL mis2_rdata: got %h exp 11223344", ReadData); end
        step();
    endtask

    task automatic test_timeout();
        // cycle 0
        Adr = 32'h300; MemRead = 1'b1;
        step();
        MemRead = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL to_m_req c%0d: got %b exp 1", c, m_req); end
            checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL to_ready_early c%0d: got %b exp 0", c, MemReady); end
            step();
        end
        // cycle 5
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL to_ready: got %b exp 1", MemReady); end
        checks++; if (MemErr !== 1'b1) begin failures++; $display("FAIL to_err: got %b exp 1", MemErr); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL to_m_req_drop: got %b exp 0", m_req); end
        step();
        // cycle 6: late ack
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL to_ready_pulse: got %b exp 0", MemReady); end
        step();
        // cycle 7
        m_ack = 1'b0;
        checks++; if (ReadData !== 32'h11223344) begin failures++; $display("FAIL to_late_ack_rdata: got %h exp 11223344", ReadData); end
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL to_late_ack_ready: got %b exp 0", MemReady); end
        checks++; if (MemErr !== 1'b1) begin failures++; $display("FAIL to_err_hold: got %b exp 1", MemErr); end
        step();
    endtask

    task automatic test_reset_mid_access();
        // cycle 0
        Adr = 32'h400; WriteData = 32'h77777777; MemRead = 1'b1;
        step();
        // cycle 1
        MemRead = 1'b0;
        checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL rm_m_req: got %b exp 1", m_req); end
        step();
        // cycle 2
        reset = 1'b0;
        step();
        // cycle 3
        reset = 1'b1; m_ack = 1'b1; m_rdata = 32'h55555555;
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rm_m_req_drop: got %b exp 0", m_req); end
        checks++; if (m_addr !== 32'h0) begin failures++; $display("FAIL rm_m_addr: got %h exp 0", m_addr); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rm_rdata: got %h exp 0", ReadData); end
        checks++; if (MemErr !== 1'b0) begin failures++; $display("FAIL rm_err: got %b exp 0", MemErr); end
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL rm_ready: got %b exp 0", MemReady); end
        step();
        // cycle 4
        m_ack = 1'b0;
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL rm_ack_ready: got %b exp 0", MemReady); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rm_ack_rdata: got %h exp 0", ReadData); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rm_ack_m_req: got %b exp 0", m_req); end
        step();
    endtask

    task automatic test_back_to_back();
        // cycle 0: both strobes, write wins
        Adr = 32'h500; WriteData = 32'h12345678; MemRead = 1'b1; MemWrite = 1'b1;
        step();
        // cycle 1
        MemRead = 1'b0; MemWrite = 1'b0;
        checks++; if (m_we !== 1'b1) begin failures++; $display("FAIL bb_m_we: got %b exp 1", m_we); end
        checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL bb_m_req: got %b exp 1", m_req); end
        checks++; if (m_wdata !== 32'h12345678) begin failures++; $display("FAIL bb_m_wdata: got %h exp 12345678", m_wdata); end
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        step();
        // cycle 2: first MemReady, write left ReadData alone
        m_ack = 1'b0;
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL bb_ready1: got %b exp 1", MemReady); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL bb_rdata1: got %h exp 0", ReadData); end
        step();
        // cycle 3: second request issued
        Adr = 32'h504; MemRead = 1'b1;
        checks++; if (MemReady !== 1'b0) begin failures++; $display("FAIL bb_ready_gap: got %b exp 0", MemReady); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL bb_m_req_gap: got %b exp 0", m_req); end
        step();
        // cycle 4: m_req two cycles after the first MemReady
        MemRead = 1'b0;
        checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL bb_m_req2: got %b exp 1", m_req); end
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL bb_m_we2: got %b exp 0", m_we); end
        checks++; if (m_addr !== 32'h504) begin failures++; $display("FAIL bb_m_addr2: got %h exp 00000504", m_addr); end
        m_ack = 1'b1; m_rdata = 32'hA5A5A5A5;
        step();
        // cycle 5
        m_ack = 1'b0;
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL bb_ready2: got %b exp 1", MemReady); end
        checks++; if (ReadData !== 32'hA5A5A5A5) begin failures++; $display("FAIL bb_rdata2: got %h exp a5a5a5a5", ReadData); end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
